// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the keypad column scanner.
package keypad_pkg;

    localparam int DEB_LAT    = 3;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lsb_idx(input logic [31:0] v);
        lsb_idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lsb_idx = i;
        end
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_fifo.sv
// Synchronous key-code FIFO with a registered head output (dout).
// Push and pop may coincide at any fill level, including full.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_after;
    logic [CW-1:0]    count, count_pop, count_nxt;
    logic [WIDTH-1:0] head_nxt;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign count_pop = count - CW'(pop);
    assign count_nxt = count_pop + CW'(push);
    assign rd_after  = rd_ptr + AW'(pop);
    // When the queue drains to nothing before this push, the new head bypasses the array
    assign head_nxt  = (count_pop == '0) ? din : mem[rd_after];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_after;
            count <= count_nxt;
            if (count_nxt != '0) dout <= head_nxt;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column-scan sequencer: strobes columns, captures debounced press edges,
// suppresses held keys and queues key codes. Optional: KEYPAD_SCAN_DROP_EN (drop on full FIFO).
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int NUM_COLS     = 4,
    parameter int NUM_ROWS     = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int GAP_CYCLES   = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int CODE_W      = $clog2(NUM_COLS) + $clog2(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    output logic [NUM_COLS-1:0] col,
    output logic                deb_en,
    input  logic [NUM_ROWS-1:0] deb_btn,
    input  logic [NUM_ROWS-1:0] row_lvl,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    input  logic                key_ready,
    output logic                key_ovf
);

    localparam int CIDX_W = $clog2(NUM_COLS);
    localparam int RIDX_W = $clog2(NUM_ROWS);
    localparam int TMAX   = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'(DWELL_CYCLES - 1);

    scan_state_t                       state, state_nxt;
    logic [TMR_W-1:0]                  timer, timer_nxt;
    logic [CIDX_W-1:0]                 col_idx, col_idx_nxt;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0] held, held_nxt;
    logic [NUM_ROWS-1:0]               pending, pend_nxt, pend_left, cap_new, sel_mask;
    logic [RIDX_W-1:0]                 row_sel;
    logic [CODE_W-1:0]                 push_code;
    logic                              in_drive, dwell_done, ser_req, push, pop, full, empty;

    assign in_drive   = (state == DRIVE);
    assign dwell_done = in_drive && (timer == DWELL_LAST);
    assign cap_new    = in_drive ? (deb_btn & ~held[col_idx]) : '0;

    // Serializer: lowest pending row goes first, at most one code per cycle
    assign ser_req   = scan_en && (pending != '0);
    assign row_sel   = RIDX_W'(lsb_idx(32'(pending)));
    assign sel_mask  = NUM_ROWS'(1) << row_sel;
    assign push_code = {col_idx, row_sel};
    assign pop       = key_valid && key_ready;
    assign push      = ser_req && (!full || pop);

`ifdef KEYPAD_SCAN_DROP_EN
    assign pend_left = ser_req ? (pending & ~sel_mask) : pending;
`else
    assign pend_left = push ? (pending & ~sel_mask) : pending;
`endif
    assign pend_nxt = scan_en ? (pend_left | cap_new) : '0;

    always_comb begin
        held_nxt = held;
        if (in_drive) begin
            held_nxt[col_idx] = held[col_idx] | deb_btn;
            if (dwell_done) held_nxt[col_idx] = held_nxt[col_idx] & row_lvl;
        end
        if (!scan_en) held_nxt = '0;
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        col_idx_nxt = col_idx;
        col         = '0;
        deb_en      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = GAP;
                timer_nxt = '0;
            end
            GAP: begin
                deb_en = 1'b1;
                if (timer == GAP_LAST) begin
                    state_nxt = DRIVE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            DRIVE: begin
                col    = NUM_COLS'(1) << col_idx;
                deb_en = 1'b1;
                // The column is only released once every captured row has left pending
                if (dwell_done) begin
                    if ((pend_left | cap_new) == '0) begin
                        state_nxt   = GAP;
                        timer_nxt   = '0;
                        col_idx_nxt = col_idx + CIDX_W'(1);
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!scan_en) begin
            state_nxt   = IDLE;
            timer_nxt   = '0;
            col_idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            col_idx <= '0;
            held    <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            col_idx <= col_idx_nxt;
            held    <= held_nxt;
            pending <= pend_nxt;
        end
    end

`ifdef KEYPAD_SCAN_DROP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  key_ovf <= 1'b0;
        else if (ser_req && !push) key_ovf <= 1'b1;
    end
`else
    assign key_ovf = 1'b0;
`endif

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_code),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .dout  (key_code)
    );

    assign key_valid = !empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with a keypad/debouncer emulation and a press-order scoreboard.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int NC    = 4;
    localparam int NR    = 4;
    localparam int DWELL = 8;
    localparam int GAPC  = 4;
    localparam int DEPTH = 4;
`ifdef KEYPAD_SCAN_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, scan_en, deb_en, key_valid, key_ready, key_ovf;
    logic [NC-1:0] col;
    logic [NR-1:0] deb_btn, row_lvl;
    key_code_t     key_code;

    int n_cmp = 0;
    int n_bad = 0;

    bit                     auto_kp;
    logic [NC-1:0][NR-1:0]  pressed;
    int                     dcnt [NR];
    logic [3:0]             got [$];
    logic [3:0]             expq [$];

    typedef struct {
        int              c;
        logic [NR-1:0]   btn;
        int              n;
        logic [2:0][3:0] codes;
    } cap_vec_t;

    cap_vec_t tbl [5];

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .DWELL_CYCLES(DWELL),
        .GAP_CYCLES(GAPC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .col(col), .deb_en(deb_en),
        .deb_btn(deb_btn), .row_lvl(row_lvl), .key_valid(key_valid),
        .key_code(key_code), .key_ready(key_ready), .key_ovf(key_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Keypad matrix plus debouncer: rows read the pressed keys of the driven column,
    // and a row pulses once after DEB_LAT consecutive high cycles.
    task automatic kp_update();
        logic [NR-1:0] lvl;
        logic [NR-1:0] pul;
        lvl = '0;
        pul = '0;
        for (int c = 0; c < NC; c++) if (col[c]) lvl = pressed[c];
        for (int r = 0; r < NR; r++) begin
            if (lvl[r] && deb_en) begin
                if (dcnt[r] < 7) dcnt[r]++;
            end else begin
                dcnt[r] = 0;
            end
            pul[r] = (dcnt[r] == DEB_LAT);
        end
        row_lvl = lvl;
        deb_btn = pul;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_kp) kp_update();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        scan_en   = 1'b0;
        key_ready = 1'b0;
        deb_btn   = '0;
        row_lvl   = '0;
        auto_kp   = 1'b0;
        pressed   = '0;
        for (int r = 0; r < NR; r++) dcnt[r] = 0;
        got.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_col(input logic [NC-1:0] tgt, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (col == tgt) break;
            tick();
        end
        chk("reach_col", 32'(col), 32'(tgt));
    endtask

    task automatic pulse_at(input int c, input logic [NR-1:0] btn);
        wait_col(NC'(1) << c, 300);
        repeat (2) tick();
        deb_btn = btn;
        row_lvl = btn;
        tick();
        deb_btn = '0;
        row_lvl = '0;
    endtask

    task automatic collect(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (key_valid && key_ready) got.push_back(key_code);
            tick();
        end
    endtask

    task automatic run_rand(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            key_ready = 1'($urandom_range(0, 1));
            if (key_valid && key_ready) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    chk("rand_code", 32'(key_code), 32'(expq[0]));
                    void'(expq.pop_front());
                end
            end
            tick();
        end
    endtask

    initial begin
        logic [NC-1:0] tgt;

        tbl[0] = '{1, 4'b0100, 1, {4'h0, 4'h0, 4'b0110}};
        tbl[1] = '{3, 4'b1011, 3, {4'b1111, 4'b1101, 4'b1100}};
        tbl[2] = '{0, 4'b0001, 1, {4'h0, 4'h0, 4'b0000}};
        tbl[3] = '{2, 4'b1000, 1, {4'h0, 4'h0, 4'b1011}};
        tbl[4] = '{3, 4'b0110, 2, {4'h0, 4'b1110, 4'b1101}};

        // Reset values
        do_reset();
        chk("rst_col", 32'(col), 32'h0);
        chk("rst_deb_en", 32'(deb_en), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_ovf", 32'(key_ovf), 32'h0);

        // Async reset in the middle of a DRIVE of col 2 with a row pending
        scan_en = 1'b1;
        pulse_at(2, 4'b0010);
        rst = 1'b1;
        #1;
        chk("arst_col", 32'(col), 32'h0);
        chk("arst_deb_en", 32'(deb_en), 32'h0);
        chk("arst_valid", 32'(key_valid), 32'h0);
        tick();
        rst = 1'b0;
        key_ready = 1'b1;
        collect(100);
        chk("arst_no_code", 32'(got.size()), 32'd0);
        pulse_at(2, 4'b0010);
        collect(20);
        chk("arst_repress_n", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("arst_repress_code", 32'(got[0]), 32'b1001);

        // Single-pulse captures: column hold while pending drains, code order and latency
        for (int i = 0; i < 5; i++) begin
            do_reset();
            scan_en   = 1'b1;
            key_ready = 1'b1;
            tgt = NC'(1) << tbl[i].c;
            wait_col(tgt, 300);
            repeat (DWELL - 1) tick();
            deb_btn = tbl[i].btn;
            row_lvl = tbl[i].btn;
            tick();
            deb_btn = '0;
            row_lvl = '0;
            for (int k = 0; k <= tbl[i].n; k++) begin
                chk($sformatf("tbl%0d_col%0d", i, k), 32'(col), (k < tbl[i].n) ? 32'(tgt) : 32'h0);
                if (k >= 1) begin
                    chk($sformatf("tbl%0d_valid%0d", i, k), 32'(key_valid), 32'h1);
                    chk($sformatf("tbl%0d_code%0d", i, k), 32'(key_code), 32'(tbl[i].codes[k-1]));
                end
                tick();
            end
            chk($sformatf("tbl%0d_drained", i), 32'(key_valid), 32'h0);
        end

        // Held key reported once over several rounds; release then re-press reports again
        do_reset();
        auto_kp   = 1'b1;
        scan_en   = 1'b1;
        key_ready = 1'b1;
        pressed[1][2] = 1'b1;
        collect(4 * (DWELL + GAPC) * 3 + 40);
        chk("hold_n", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("hold_code", 32'(got[0]), 32'b0110);
        pressed = '0;
        collect(120);
        chk("release_n", 32'(got.size()), 32'd1);
        pressed[1][2] = 1'b1;
        collect(120);
        chk("repress_n", 32'(got.size()), 32'd2);
        if (got.size() > 1) chk("repress_code", 32'(got[1]), 32'b0110);

        // FIFO full with the consumer stalled: five distinct presses
        do_reset();
        scan_en = 1'b1;
        pulse_at(0, 4'b1111);
        pulse_at(1, 4'b0001);
        repeat (30) tick();
        chk("full_valid", 32'(key_valid), 32'h1);
        chk("full_head", 32'(key_code), 32'h0);
        chk("full_ovf", 32'(key_ovf), 32'(DROP));
        if (!DROP) chk("full_stall_col", 32'(col), 32'b0010);
        key_ready = 1'b1;
        collect(20);
        chk("full_n", 32'(got.size()), DROP ? 32'd4 : 32'd5);
        for (int i = 0; i < got.size(); i++) chk($sformatf("full_code%0d", i), 32'(got[i]), 32'(i));

        // Scan disabled with two codes queued: column off, queue still drains in order
        do_reset();
        scan_en = 1'b1;
        pulse_at(0, 4'b0011);
        repeat (3) tick();
        scan_en = 1'b0;
        tick();
        chk("off_col", 32'(col), 32'h0);
        chk("off_deb_en", 32'(deb_en), 32'h0);
        chk("off_valid", 32'(key_valid), 32'h1);
        key_ready = 1'b1;
        collect(10);
        chk("off_n", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("off_code0", 32'(got[0]), 32'b0000);
            chk("off_code1", 32'(got[1]), 32'b0001);
        end
        chk("off_empty", 32'(key_valid), 32'h0);

        // Random single-key presses against the press-order scoreboard, random consumer stalls
        do_reset();
        auto_kp = 1'b1;
        scan_en = 1'b1;
        expq.delete();
        for (int p = 0; p < 12; p++) begin
            int c, r;
            c = int'($urandom_range(0, NC - 1));
            r = int'($urandom_range(0, NR - 1));
            pressed[c][r] = 1'b1;
            expq.push_back({2'(c), 2'(r)});
            run_rand(int'($urandom_range(100, 180)));
            pressed = '0;
            run_rand(int'($urandom_range(100, 180)));
        end
        key_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (key_valid) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    chk("rand_code", 32'(key_code), 32'(expq[0]));
                    void'(expq.pop_front());
                end
            end
            tick();
        end
        chk("rand_left", 32'(expq.size()), 32'd0);
        chk("rand_ovf", 32'(key_ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Column-scan sequencer for the 4x4 call/floor keypad. Drives one-hot column strobes and gates the debouncing block's en, then turns its single-cycle rising-edge pulses (buttonMux) into unique key codes. Tracks held keys so a held key is reported once, and queues codes in a small FIFO with a valid/ready handshake toward the elevator request logic.

Parameters:
NUM_COLS, 4, number of keypad columns strobed (power of 2)
NUM_ROWS, 4, row width; must match debouncing row/buttonMux width
DWELL_CYCLES, 8, cycles a column stays driven; must be >= DEB_LAT+2
GAP_CYCLES, 4, all-columns-off cycles between columns; must be >= DEB_LAT
FIFO_DEPTH, 4, key code queue depth (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
scan_en  in  1  level; 1 = scanning runs
col  out  NUM_COLS  one-hot column drive, 0 during gap/idle
deb_en  out  1  to debouncing.en
deb_btn  in  NUM_ROWS  from debouncing.buttonMux (1-cycle rising-edge pulses)
row_lvl  in  NUM_ROWS  synchronized raw row level, used for release detection
key_valid  out  1  FIFO not empty
key_code  out  CODE_W  {col_idx, row_idx} of FIFO head
key_ready  in  1  consumer pop; pop occurs when key_valid & key_ready
key_ovf  out  1  sticky drop flag (see Optional Feature)

Behaviour:
- Reset (async): state IDLE, col=0, deb_en=0, col_idx=0, timer=0, held=0, pending=0, FIFO empty, key_valid=0, key_code=0, key_ovf=0.
- FSM IDLE -> GAP when scan_en=1. GAP: col=0, deb_en=1, GAP_CYCLES cycles, then -> DRIVE. DRIVE: col=1<<col_idx, deb_en=1, DWELL_CYCLES cycles.
- DRIVE exit: only when timer expired AND pending==0; then col_idx wraps NUM_COLS-1 -> 0 and -> GAP. Otherwise stays in DRIVE (col held) until pending drains.
- Capture: only in DRIVE; new = deb_btn & ~held[col_idx]; pending |= new; held[col_idx] |= deb_btn. Pulses in GAP/IDLE ignored.
- Release: on last DRIVE timer cycle, held[col_idx][r] cleared for every r with row_lvl[r]==0.
- Serialize: each cycle, lowest-index set pending bit pushed as {col_idx,r} if FIFO can accept; that bit cleared. One push per cycle max.
- FIFO: push and pop in the same cycle legal when full (count unchanged). key_code registered from head; pop of last entry -> key_valid=0 next cycle.
- scan_en=0 in any state: next cycle IDLE, col=0, deb_en=0, pending and held cleared, col_idx=0; FIFO contents retained and still poppable.
- CODE_W = $clog2(NUM_COLS)+$clog2(NUM_ROWS); all counters wrap silently only where stated.
- Latency: press edge on deb_btn -> key_valid at earliest 2 cycles later (pending reg, FIFO write).

Optional Feature:
KEYPAD_SCAN_DROP_EN: when defined, FIFO full never stalls DRIVE; the pending bit that would be pushed is discarded and key_ovf set (sticky until rst). When undefined, full FIFO holds the bit in pending, DRIVE extends, and key_ovf is tied 0.

Decomposition:
- Package keypad_pkg: DEB_LAT=3 (debouncer pipeline depth), scan state enum (IDLE, GAP, DRIVE), key_code_t typedef, function for lowest-set-bit index.
- Sub-module key_fifo (sync FIFO, FIFO_DEPTH x CODE_W, push/pop/full/empty, async active-high rst).

Test Plan:
- Reset mid-DRIVE of col 2 with pending=0010 -> next clk col=0000, deb_en=0, key_valid=0, held/pending cleared.
- scan_en=1, key (col1,row2) pressed, debouncer model pulses deb_btn=0100 in DRIVE of col1 -> single key_code=4'b0110, key_valid=1 until key_ready pops it.
- Same key held for 3 full scan rounds -> no further codes; release (row_lvl[2]=0 at dwell end) then press again -> second 4'b0110.
- deb_btn=1011 in one DRIVE cycle of col3 -> codes 1100, 1101, 1111 in that order on consecutive pushes; col advance waits for pending empty.
- key_ready=0, 5 distinct presses with FIFO_DEPTH=4 -> without macro: 4 queued, scan stalls in DRIVE, 5th code delivered after one pop; with KEYPAD_SCAN_DROP_EN: 4 queued, key_ovf=1, 5th lost.
- scan_en dropped with 2 codes queued -> col=0, deb_en=0 next cycle; both codes still popped in order.
